// File: rtl/mult_pkg.sv
// Shared types and constants for the mult_seq shift-and-add multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter width; guarded so a 1-bit operand still gets a counter bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/result bundle between the EX stage and mult_seq.
// MULT_SIGNED_EN adds the signed_op request bit.
interface mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef MULT_SIGNED_EN
  logic             signed_op;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MULT_SIGNED_EN
  modport master (output start, a, b, signed_op, input ready, busy, done, hi, lo);
  modport slave  (input start, a, b, signed_op, output ready, busy, done, hi, lo);
`else
  modport master (output start, a, b, input ready, busy, done, hi, lo);
  modport slave  (input start, a, b, output ready, busy, done, hi, lo);
`endif
endinterface

// File: rtl/mult_seq_add_cw.sv
// WIDTH-bit adder with carry-in and carry-out, shared by every RUN iteration.
module add_cw #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_in0} + {1'b0, i_in1} + {{WIDTH{1'b0}}, i_cin};
endmodule

// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier producing a 2*WIDTH-bit product as hi/lo.
// Optional MULT_SIGNED_EN adds signed_op and a one-cycle NEG fix-up state.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic      clk,
  input logic      rst_n,
  mult_seq_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam int W2    = 2 * WIDTH;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [W2-1:0]    r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_mcand, r_hi, r_lo;
  logic [WIDTH-1:0] w_a_op, w_b_op, w_addend, w_sum;
  logic             w_cout, w_last;

`ifdef MULT_SIGNED_EN
  logic r_sop, r_sneg;

  // abs() of the most-negative value wraps to itself, which is 2^(W-1) read unsigned.
  assign w_a_op = (bus.signed_op && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
  assign w_b_op = (bus.signed_op && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
`else
  assign w_a_op = bus.a;
  assign w_b_op = bus.b;
`endif

  assign w_addend = r_acc[0] ? r_mcand : '0;
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));

  add_cw #(.WIDTH(WIDTH)) u_add (
    .i_in0  (r_acc[W2-1:WIDTH]),
    .i_in1  (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_acc_nxt   = {{WIDTH{1'b0}}, w_b_op};
        end
      end
      RUN: begin
        w_acc_nxt = {w_cout, w_sum, r_acc[WIDTH-1:1]};
        if (w_last) begin
`ifdef MULT_SIGNED_EN
          w_state_nxt = r_sop ? NEG : DONE;
`else
          w_state_nxt = DONE;
`endif
        end
      end
      NEG: begin
`ifdef MULT_SIGNED_EN
        w_acc_nxt = r_sneg ? (~r_acc + W2'(1)) : r_acc;
`endif
        w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULT_SIGNED_EN
      r_sop   <= 1'b0;
      r_sneg  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      if (r_state == IDLE && bus.start) begin
        r_mcand <= w_a_op;
        r_count <= '0;
`ifdef MULT_SIGNED_EN
        r_sop   <= bus.signed_op;
        r_sneg  <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`endif
      end else if (r_state == RUN) begin
        r_count <= r_count + CNT_W'(1);
      end
      // Result registers move only on the edge that enters DONE.
      if (w_state_nxt == DONE && r_state != DONE) begin
        {r_hi, r_lo} <= w_acc_nxt;
      end
    end
  end

  assign bus.ready = (r_state == IDLE);
  assign bus.busy  = (r_state == RUN) || (r_state == NEG);
  assign bus.done  = (r_state == DONE);
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule
